// File: rtl/key_lookup_table_pkg.sv
// Shared constants and elaboration-time helpers for the key lookup table.
package key_lookup_table_pkg;

  localparam bit MISS_ZERO    = 1'b0;
  localparam bit MISS_DEFAULT = 1'b1;

  function automatic int clog2(input int n);
    for (int r = 0; r < 31; r++) begin
      if ((32'sd1 << r) >= n) return r;
    end
    return 31;
  endfunction

  // An index needs at least one bit, even for a single-entry table.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/key_lookup_table_match_prio.sv
// Priority resolver: lowest matching entry index, any-hit and multi-hit flags.
module key_match_prio
  import key_lookup_table_pkg::*;
#(
  parameter int NR_KEY = 8,
  parameter int IDX_W  = idx_width(NR_KEY)
) (
  input  logic [NR_KEY-1:0] match_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              multi_o
);

  // Walk upward: the first match claims the index, any later one marks multi.
  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    multi_o = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match_i[i]) begin
        if (hit_o) begin
          multi_o = 1'b1;
        end else begin
          hit_o = 1'b1;
          idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/key_lookup_table.sv
// Programmable key->data lookup table with a single registered response stage
// and valid/ready handshakes on both the request and the response side.
module key_lookup_table
  import key_lookup_table_pkg::*;
#(
  parameter int NR_KEY      = 8,
  parameter int KEY_LEN     = 6,
  parameter int DATA_LEN    = 32,
  parameter bit HAS_DEFAULT = MISS_ZERO,
  parameter int IDX_W       = idx_width(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                wr_set,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic                rsp_multi,
  output logic [IDX_W:0]      occupancy
);

  logic [NR_KEY-1:0]   valid_q, valid_d, match_s;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [KEY_LEN-1:0]  key_d  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];

  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;
  logic                rsp_multi_q, rsp_multi_d;
  logic [IDX_W:0]      occupancy_q, occupancy_d;

  logic                prio_hit_s, prio_multi_s, accept_s;
  logic [IDX_W-1:0]    prio_idx_s;
  logic [DATA_LEN-1:0] hit_data_s;

  // Clear first, then the write; indices past the last entry match no slot.
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    if (clr) valid_d = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        valid_d[i] = wr_set;
        if (wr_set) begin
          key_d[i]  = wr_key;
          data_d[i] = wr_data;
        end
      end
    end
  end

  // Lookups compare against the registered table, so same-cycle writes are unseen.
  always_comb begin
    match_s    = '0;
    hit_data_s = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match_s[i] = valid_q[i] && (key_q[i] == req_key);
      if (prio_idx_s == IDX_W'(i)) hit_data_s = data_q[i];
    end
  end

  key_match_prio #(
    .NR_KEY (NR_KEY),
    .IDX_W  (IDX_W)
  ) u_prio (
    .match_i (match_s),
    .hit_o   (prio_hit_s),
    .idx_o   (prio_idx_s),
    .multi_o (prio_multi_s)
  );

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept_s  = req_valid && req_ready;

  // Response stage: load on accept, otherwise drop valid once consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_multi_d = rsp_multi_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_hit_d   = prio_hit_s;
      rsp_idx_d   = prio_idx_s;
      rsp_multi_d = prio_multi_s;
      if (prio_hit_s) begin
        rsp_data_d = hit_data_s;
      end else if (HAS_DEFAULT == MISS_DEFAULT) begin
        rsp_data_d = default_out;
      end else begin
        rsp_data_d = '0;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Occupancy is registered alongside the valid bits it counts.
  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      occupancy_d = occupancy_d + {{IDX_W{1'b0}}, valid_d[i]};
    end
  end

  // State registers; reset wins over writes, clears and requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_multi_q <= 1'b0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      key_q       <= key_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_multi_q <= rsp_multi_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_multi = rsp_multi_q;
  assign occupancy = occupancy_q;

endmodule
